page_loop_nch: RTL



---
 rtl/page_loop_pkg.sv | 27 ++
 rtl/page_loop_nch_if.sv | 27 ++
 rtl/page_loop_chan.sv | 82 ++++++++
 rtl/page_loop_nch.sv | 40 ++++
 4 files changed

// File: rtl/page_loop_pkg.sv
// Shared types and elaboration helpers for the page_loop leaf loopback.
package page_loop_pkg;

  localparam int PKT_W_DEF = 49;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } chan_state_t;

  function automatic int valid_bit(input int pkt_w);
    return pkt_w - 1;
  endfunction

  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/page_loop_nch_if.sv
// Per-channel bundle between the leaf-side bus slicer and one loopback channel.
interface page_loop_nch_if
  import page_loop_pkg::*;
#(
  parameter int PKT_W = PKT_W_DEF,
  parameter int CNT_W = 8
);

  logic [PKT_W-1:0] din;
  logic [PKT_W-1:0] dout;
  logic             resend;
  logic             ap_start;
  logic             overflow;
  logic [CNT_W-1:0] drop_cnt;
  logic             fifo_empty;

  modport master (
    output din, resend, ap_start,
    input  dout, overflow, drop_cnt, fifo_empty
  );

  modport slave (
    input  din, resend, ap_start,
    output dout, overflow, drop_cnt, fifo_empty
  );

endinterface

// File: rtl/page_loop_chan.sv
// One loopback channel: capture FIFO, run/idle FSM, replay register, drop accounting.
//   state   | meaning
//   ST_IDLE | capture only, no replay
//   ST_RUN  | capture, and replay one word per cycle while resend is high
module page_loop_chan
  import page_loop_pkg::*;
#(
  parameter int PKT_W = PKT_W_DEF,
  parameter int DEPTH = 8,
  parameter int CNT_W = 8
) (
  input  logic            clk,
  input  logic            reset,
  page_loop_nch_if.slave  bus
);

  localparam int AW = clog2(DEPTH);
  localparam int VB = valid_bit(PKT_W);

  chan_state_t      r_state;
  chan_state_t      w_state_nxt;
  logic [PKT_W-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wptr;
  logic [AW:0]      r_rptr;
  logic [PKT_W-1:0] r_dout;
  logic             r_ovf;
  logic [CNT_W-1:0] r_cnt;

  logic w_empty;
  logic w_full;
  logic w_push;
  logic w_pop;
  logic w_wr;
  logic w_drop;

  assign w_empty = (r_wptr == r_rptr);
  assign w_full  = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
  assign w_push  = bus.din[VB];
  assign w_pop   = (r_state == ST_RUN) && bus.resend && !w_empty;
  // A pop frees the head slot at the same edge, so a full FIFO still accepts.
  assign w_wr    = w_push && (!w_full || w_pop);
  assign w_drop  = w_push && w_full && !w_pop;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (bus.ap_start)  w_state_nxt = ST_RUN;
      ST_RUN:  if (!bus.ap_start) w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= ST_IDLE;
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_dout  <= '0;
      r_ovf   <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_wr)  r_wptr <= r_wptr + (AW+1)'(1);
      if (w_pop) r_rptr <= r_rptr + (AW+1)'(1);
      r_dout <= w_pop ? r_mem[r_rptr[AW-1:0]] : '0;
      if (w_drop) begin
        r_ovf <= 1'b1;
        if (r_cnt != {CNT_W{1'b1}}) r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wptr[AW-1:0]] <= bus.din;
  end

  assign bus.dout       = r_dout;
  assign bus.overflow   = r_ovf;
  assign bus.drop_cnt   = r_cnt;
  assign bus.fifo_empty = w_empty;

endmodule

// File: rtl/page_loop_nch.sv
// N-channel leaf loopback page: slices the flat BFT buses onto independent channels.
module page_loop_nch
  import page_loop_pkg::*;
#(
  parameter int NCH   = 4,
  parameter int PKT_W = PKT_W_DEF,
  parameter int DEPTH = 8,
  parameter int CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NCH*PKT_W-1:0] din_leaf_bft2interface,
  output logic [NCH*PKT_W-1:0] dout_leaf_interface2bft,
  input  logic [NCH-1:0]       resend,
  input  logic [NCH-1:0]       ap_start,
  output logic [NCH-1:0]       overflow,
  output logic [NCH*CNT_W-1:0] drop_cnt,
  output logic [NCH-1:0]       fifo_empty
);

  for (genvar g = 0; g < NCH; g++) begin : g_chan
    page_loop_nch_if #(.PKT_W(PKT_W), .CNT_W(CNT_W)) u_if ();

    assign u_if.din      = din_leaf_bft2interface[g*PKT_W +: PKT_W];
    assign u_if.resend   = resend[g];
    assign u_if.ap_start = ap_start[g];

    page_loop_chan #(.PKT_W(PKT_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) u_chan (
      .clk   (clk),
      .reset (reset),
      .bus   (u_if.slave)
    );

    assign dout_leaf_interface2bft[g*PKT_W +: PKT_W] = u_if.dout;
    assign overflow[g]                   = u_if.overflow;
    assign drop_cnt[g*CNT_W +: CNT_W]    = u_if.drop_cnt;
    assign fifo_empty[g]                 = u_if.fifo_empty;
  end

endmodule
